// File: rtl/line_refill_ctrl.sv
// line_refill_ctrl: cache-miss refill sequencer.
// Reads one line word-by-word over req/ack, then pulses the full line out.
module line_refill_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 27
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             miss_valid,
    input  logic [ADDR_W-1:0]                miss_addr,
    output logic                             miss_ready,
    output logic                             mem_req,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic                             mem_ack,
    input  logic [DATA_W-1:0]                mem_rdata,
    output logic                             fill_valid,
    output logic [ADDR_W-1:0]                fill_addr,
    output logic [WORDS_PER_LINE*DATA_W-1:0] fill_data,
    output logic                             busy
);

    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam int OFF   = IDX_W + 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF) - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             capture;
    logic             last;

    assign accept  = (state == IDLE) && miss_valid;
    assign capture = (state == REQ) && mem_ack;
    assign last    = (idx == LAST_IDX);

    always_comb begin
        state_next = state;
        miss_ready = 1'b0;
        mem_req    = 1'b0;
        fill_valid = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) state_next = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (capture && last) state_next = DONE;
            end
            DONE: begin
                fill_valid = 1'b1;
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // fill_data doubles as the line buffer; aligned lines never carry out
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            mem_addr  <= '0;
            fill_addr <= '0;
            fill_data <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                idx       <= '0;
                mem_addr  <= miss_addr & LINE_MASK;
                fill_addr <= miss_addr & LINE_MASK;
            end
            if (capture) begin
                for (int i = 0; i < WORDS_PER_LINE; i++) begin
                    if (idx == IDX_W'(i)) begin
                        fill_data[i*DATA_W +: DATA_W] <= mem_rdata;
                    end
                end
                if (!last) begin
                    idx      <= idx + IDX_W'(1);
                    mem_addr <= mem_addr + ADDR_W'(4);
                end
            end
        end
    end

endmodule

// File: tb/tb_line_refill_ctrl.sv
// tb_line_refill_ctrl: vector table, directed corner cases and
// randomized traffic checked against a transaction-level model.
module tb_line_refill_ctrl;

    localparam int W    = 4;
    localparam int DW   = 32;
    localparam int AW   = 27;
    localparam int FD_W = W * DW;

    logic            clk;
    logic            rst;
    logic            miss_valid;
    logic [AW-1:0]   miss_addr;
    logic            miss_ready;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;
    logic            fill_valid;
    logic [AW-1:0]   fill_addr;
    logic [FD_W-1:0] fill_data;
    logic            busy;

    int checks;
    int failures;

    line_refill_ctrl #(
        .WORDS_PER_LINE(W),
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .miss_valid(miss_valid),
        .miss_addr(miss_addr),
        .miss_ready(miss_ready),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .fill_valid(fill_valid),
        .fill_addr(fill_addr),
        .fill_data(fill_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: words captured so far and a pending fill
    bit            m_active;
    bit            m_done;
    int            m_words;
    logic [AW-1:0] m_base;
    logic [DW-1:0] m_data [W];

    function automatic logic [FD_W-1:0] m_line();
        logic [FD_W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) v[i*DW +: DW] = m_data[i];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [FD_W-1:0] act,
                       input logic [FD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic mv,
                              input logic [AW-1:0] a, input logic k,
                              input logic [DW-1:0] d);
        int line_bytes;
        line_bytes = W * 4;
        if (r) begin
            m_active = 0;
            m_done   = 0;
            m_words  = 0;
            m_base   = '0;
            for (int i = 0; i < W; i++) m_data[i] = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (k) begin
                m_data[m_words] = d;
                m_words++;
                if (m_words == W) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end else if (mv) begin
            m_active = 1;
            m_words  = 0;
            m_base   = a - AW'(int'(a) % line_bytes);
        end
    endtask

    task automatic cyc(input logic r, input logic mv, input logic [AW-1:0] a,
                       input logic k, input logic [DW-1:0] d);
        rst        = r;
        miss_valid = mv;
        miss_addr  = a;
        mem_ack    = k;
        mem_rdata  = d;
        @(posedge clk);
        model_step(r, mv, a, k, d);
        #1;
        chk("m_req", FD_W'(mem_req), FD_W'(m_active));
        chk("m_ready", FD_W'(miss_ready), FD_W'(!m_active && !m_done));
        chk("m_busy", FD_W'(busy), FD_W'(m_active || m_done));
        chk("m_fill_valid", FD_W'(fill_valid), FD_W'(m_done));
        chk("m_fill_addr", FD_W'(fill_addr), FD_W'(m_base));
        if (m_active)
            chk("m_mem_addr", FD_W'(mem_addr), FD_W'(m_base + AW'(4 * m_words)));
        else
            chk("m_fill_data", fill_data, m_line());
    endtask

    typedef struct {
        logic            mv;
        logic [AW-1:0]   addr;
        logic            ack;
        logic [DW-1:0]   rdata;
        logic            e_req;
        logic [AW-1:0]   e_maddr;
        logic            e_fv;
        logic            e_ready;
        logic [AW-1:0]   e_faddr;
        logic [FD_W-1:0] e_fd;
    } vec_t;

    vec_t tbl [6];
    int   fv_cnt;

    initial begin
        checks   = 0;
        failures = 0;
        fv_cnt   = 0;

        tbl[0] = '{1, 27'h0001234, 1, 32'h0, 1, 27'h1230, 0, 0, 27'h1230, '0};
        tbl[1] = '{0, 27'h0, 1, 32'hA0, 1, 27'h1234, 0, 0, 27'h1230, '0};
        tbl[2] = '{0, 27'h0, 1, 32'hA1, 1, 27'h1238, 0, 0, 27'h1230, '0};
        tbl[3] = '{0, 27'h0, 1, 32'hA2, 1, 27'h123C, 0, 0, 27'h1230, '0};
        tbl[4] = '{0, 27'h0, 1, 32'hA3, 0, 27'h0, 1, 0, 27'h1230,
                   128'h000000A3_000000A2_000000A1_000000A0};
        tbl[5] = '{0, 27'h0, 1, 32'hFF, 0, 27'h0, 0, 1, 27'h1230,
                   128'h000000A3_000000A2_000000A1_000000A0};

        // reset then idle
        cyc(1, 0, '0, 0, '0);
        cyc(1, 0, '0, 0, '0);
        cyc(0, 0, '0, 0, '0);
        chk("rst_ready", FD_W'(miss_ready), FD_W'(1));
        chk("rst_req", FD_W'(mem_req), '0);
        chk("rst_mem_addr", FD_W'(mem_addr), '0);
        chk("rst_fill_valid", FD_W'(fill_valid), '0);
        chk("rst_fill_addr", FD_W'(fill_addr), '0);
        chk("rst_fill_data", fill_data, '0);
        chk("rst_busy", FD_W'(busy), '0);
        cyc(0, 0, '0, 1, 32'hDEADBEEF);
        cyc(0, 0, '0, 1, 32'hCAFEF00D);
        chk("stray_ack_data", fill_data, '0);

        // basic refill from the vector table
        for (int i = 0; i < 6; i++) begin
            cyc(0, tbl[i].mv, tbl[i].addr, tbl[i].ack, tbl[i].rdata);
            chk($sformatf("v%0d_req", i), FD_W'(mem_req), FD_W'(tbl[i].e_req));
            chk($sformatf("v%0d_fv", i), FD_W'(fill_valid), FD_W'(tbl[i].e_fv));
            chk($sformatf("v%0d_ready", i), FD_W'(miss_ready), FD_W'(tbl[i].e_ready));
            chk($sformatf("v%0d_faddr", i), FD_W'(fill_addr), FD_W'(tbl[i].e_faddr));
            if (tbl[i].e_req)
                chk($sformatf("v%0d_maddr", i), FD_W'(mem_addr), FD_W'(tbl[i].e_maddr));
            else
                chk($sformatf("v%0d_fd", i), fill_data, tbl[i].e_fd);
        end

        // stalled memory: ack every third cycle
        cyc(0, 1, 27'h0002008, 0, '0);
        for (int k = 0; k < 14; k++) begin
            cyc(0, 0, '0, 1'(k % 3 == 2), 32'hB0 + DW'(k));
            if (fill_valid) fv_cnt++;
        end
        chk("stall_fv_count", FD_W'(fv_cnt), FD_W'(1));
        chk("stall_fd", fill_data, 128'h000000BB_000000B8_000000B5_000000B2);
        chk("stall_faddr", FD_W'(fill_addr), FD_W'(27'h2000));

        // request while busy is dropped
        cyc(0, 1, 27'h0001234, 0, '0);
        cyc(0, 1, 27'h0005678, 0, '0);
        chk("busy_ready", FD_W'(miss_ready), '0);
        chk("busy_faddr", FD_W'(fill_addr), FD_W'(27'h1230));
        for (int k = 0; k < 4; k++) cyc(0, 1, 27'h0005678, 1, 32'hC0 + DW'(k));
        chk("busy_done_fv", FD_W'(fill_valid), FD_W'(1));
        chk("busy_done_faddr", FD_W'(fill_addr), FD_W'(27'h1230));
        cyc(0, 1, 27'h0005678, 0, '0);
        cyc(0, 1, 27'h0005678, 1, 32'h0);
        chk("second_faddr", FD_W'(fill_addr), FD_W'(27'h5670));
        for (int k = 0; k < 5; k++) cyc(0, 0, '0, 1, 32'hD0 + DW'(k));

        // top of address space
        cyc(0, 1, 27'h7FFFFFE, 1, '0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("top_maddr%0d", k), FD_W'(mem_addr),
                FD_W'(27'h7FFFFF0 + 27'(4 * k)));
            cyc(0, 0, '0, 1, 32'hE0 + DW'(k));
        end
        chk("top_fv", FD_W'(fill_valid), FD_W'(1));
        chk("top_faddr", FD_W'(fill_addr), FD_W'(27'h7FFFFF0));
        cyc(0, 0, '0, 0, '0);

        // reset after the second ack aborts the refill
        fv_cnt = 0;
        cyc(0, 1, 27'h0003000, 0, '0);
        cyc(0, 0, '0, 1, 32'h11);
        cyc(0, 0, '0, 1, 32'h22);
        cyc(1, 1, 27'h0004000, 1, 32'h33);
        chk("abort_req", FD_W'(mem_req), '0);
        chk("abort_fd", fill_data, '0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, '0, 1, 32'h44);
            if (fill_valid) fv_cnt++;
        end
        chk("abort_no_fv", FD_W'(fv_cnt), '0);
        cyc(0, 1, 27'h0003010, 1, '0);
        for (int k = 0; k < 4; k++) cyc(0, 0, '0, 1, 32'hF0 + DW'(k));
        chk("after_abort_fv", FD_W'(fill_valid), FD_W'(1));
        chk("after_abort_fd", fill_data, 128'h000000F3_000000F2_000000F1_000000F0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom);
            if ($urandom_range(7) == 0) a = 27'h7FFFFF0 | AW'($urandom_range(15));
            cyc(1'($urandom_range(63) == 0), 1'($urandom_range(2) == 0), a,
                1'($urandom_range(1)), DW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_refill_ctrl.md
Name: line_refill_ctrl

Overview:
Cache-miss refill sequencer that sits directly downstream of the word-to-byte address shifter. It takes the 27-bit byte address of a missing word, aligns it to the cache line base, and issues one main-memory read per word over a req/ack handshake. It packs the returned words into a line buffer and then presents the full line to the cache data/tag arrays with a one-cycle fill pulse.

Parameters:
WORDS_PER_LINE, 4, words per cache line; power of two, 2..16
DATA_W, 32, memory word width in bits
ADDR_W, 27, byte address width; matches the shifter output

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
miss_valid  input  1  refill request from the cache controller
miss_addr  input  ADDR_W  byte address of the missing word (shifter output)
miss_ready  output  1  block idle and able to accept a request
mem_req  output  1  memory read request
mem_addr  output  ADDR_W  byte address of the current word read
mem_ack  input  1  memory has returned data this cycle
mem_rdata  input  DATA_W  read data, valid when mem_ack=1
fill_valid  output  1  one-cycle pulse: line buffer complete
fill_addr  output  ADDR_W  line-aligned base address of the filled line
fill_data  output  WORDS_PER_LINE*DATA_W  word i at bits [i*DATA_W +: DATA_W]
busy  output  1  refill in progress (REQ or DONE)

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- OFF = log2(WORDS_PER_LINE)+2.
- Line base = miss_addr with bits [OFF-1:0] cleared. The low address bits are ignored.
- FSM states are IDLE, REQ and DONE.
- IDLE:
  - miss_ready=1, mem_req=0.
  - On miss_valid at a clk edge, latch the base into fill_addr, clear word index idx to 0, and go to REQ.
- REQ:
  - mem_req=1.
  - mem_addr = base + (idx<<2), registered so that it is stable while mem_req=1.
  - mem_req stays high until mem_ack is sampled.
  - On mem_ack, write mem_rdata into slot idx.
    - If idx==WORDS_PER_LINE-1, go to DONE.
    - Otherwise idx++, stay in REQ, and keep mem_req high with the next address on the following cycle.
  - Back-to-back acks are legal: one word per cycle.
- DONE:
  - fill_valid=1 for exactly one cycle, then go to IDLE.
  - fill_data and fill_addr hold their values until the next accepted miss.
- miss_ready = (state==IDLE). A miss_valid outside IDLE is ignored and not queued.
- mem_ack while in IDLE or DONE is ignored, with no buffer write.
- Address arithmetic is modulo 2^ADDR_W. Because lines are aligned, the last word never carries past base+line size; a top-of-space line (0x7FFFFF0 for 4 words) completes without wrap.
- Latency with mem_ack tied high:
  - Accept at edge A.
  - mem_req high cycles A+1..A+WORDS_PER_LINE.
  - fill_valid in cycle A+WORDS_PER_LINE+1.
  - miss_ready high again the cycle after that.
- Reset values: state IDLE, idx 0, mem_req 0, mem_addr 0, fill_valid 0, fill_addr 0, fill_data 0, busy 0, miss_ready 1 (after reset is released).
- Reset mid-refill aborts immediately: no fill_valid, the partial buffer is cleared, and mem_req is low on the next cycle.
- rst has priority over mem_ack and miss_valid when both are asserted at the same edge.

Test Plan:
- Reset then idle: rst high 2 cycles -> all outputs 0, miss_ready=1. Strobe mem_ack with no request -> fill_data stays 0.
- Basic refill, WORDS=4, mem_ack tied high, miss_addr=27'h0001234 -> mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C on 4 consecutive cycles. Returned data 0xA0..0xA3 gives fill_data = {A3,A2,A1,A0}, fill_addr=0x1230, and fill_valid for 1 cycle exactly 5 cycles after accept.
- Stalled memory: mem_ack asserted only every 3rd cycle -> mem_req and mem_addr hold steady between acks, 4 words are captured in order, and a single fill_valid pulse follows the 4th ack.
- Request while busy: second miss_valid (addr 0x5678) during REQ -> ignored, miss_ready=0, and fill_addr remains 0x1230. Reasserting it after completion gives fill_addr=0x5670.
- Top of address space: miss_addr=27'h7FFFFFE -> addresses 0x7FFFFF0..0x7FFFFFC and fill_addr=0x7FFFFF0, with no wrap.
- Reset mid-operation: rst after the 2nd ack -> no fill_valid, mem_req=0 next cycle, and fill_data=0. A new miss then completes normally.
